// File: rtl/prefix_pkg.sv
// Shared constants and elaboration helpers for the prefix subtractor pipeline.
package prefix_pkg;

    localparam int PREFIX_DEFAULT_N = 8;

    // Number of Kogge-Stone levels needed to span n bits: ceil(log2 n).
    function automatic int prefix_levels(input int n);
        int lvl;
        lvl = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'sd1 <<< lvl) < n) begin
                lvl = lvl + 1;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone black cell: merges a high (generate, propagate) group with the adjacent low group.
module prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Three-stage valid/ready subtractor: bitwise g/p, Kogge-Stone carry tree, then sum and flags.
module prefix_subtractor_pipe
    import prefix_pkg::*;
#(
    parameter int N = PREFIX_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         zero,
    output logic         ovf
);

    localparam int LEVELS = prefix_levels(N);

    logic         v1_r;
    logic         v2_r;
    logic         adv1_s;
    logic         adv2_s;
    logic         adv3_s;

    logic [N-1:0] g1_r;
    logic [N-1:0] p1_r;
    logic         cin1_r;
    logic         xmsb1_r;

    logic [N-1:0] gg2_r;
    logic [N-1:0] p2_r;
    logic         cin2_r;
    logic         xmsb2_r;

    logic [N-1:0] carry_s;
    logic [N-1:0] sum_s;
    logic         unused_s;

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv3_s   = !out_valid || out_ready;
    assign adv2_s   = !v2_r || adv3_s;
    assign adv1_s   = !v1_r || adv2_s;
    assign in_ready = adv1_s;

    // Stage valid bits; cleared asynchronously so in-flight beats are discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
        end else begin
            if (adv1_s) begin
                v1_r <= in_valid;
            end
            if (adv2_s) begin
                v2_r <= v1_r;
            end
        end
    end

    // Stage 1 data: subtraction is x + ~y + ~bin, so form g/p against the inverted subtrahend.
    always_ff @(posedge clk) begin
        if (in_valid && adv1_s) begin
            g1_r    <= x & ~y;
            p1_r    <= x ^ ~y;
            cin1_r  <= ~bin;
            xmsb1_r <= x[N-1];
        end
    end

    // Carry-in is folded into bit 0 so the tree needs only ceil(log2 N) levels.
    for (genvar l = 0; l <= LEVELS; l++) begin : lv
        logic [N-1:0] g_s;
        logic [N-1:0] p_s;
        if (l == 0) begin : base
            assign g_s = {g1_r[N-1:1], g1_r[0] | (p1_r[0] & cin1_r)};
            assign p_s = p1_r;
        end else begin : tree
            localparam int DIST = 32'sd1 <<< (l - 1);
            for (genvar j = 0; j < N; j++) begin : bit_j
                if (j < DIST) begin : pass
                    assign g_s[j] = lv[l-1].g_s[j];
                    assign p_s[j] = lv[l-1].p_s[j];
                end else begin : black
                    prefix_cell u_cell (
                        .g_hi  (lv[l-1].g_s[j]),
                        .p_hi  (lv[l-1].p_s[j]),
                        .g_lo  (lv[l-1].g_s[j-DIST]),
                        .p_lo  (lv[l-1].p_s[j-DIST]),
                        .g_out (g_s[j]),
                        .p_out (p_s[j])
                    );
                end
            end
        end
    end

    // Final-level group propagate is not needed once every carry is resolved.
    assign unused_s = ^lv[LEVELS].p_s;

    // Stage 2 data: group generate of bit i is the carry out of bit i.
    always_ff @(posedge clk) begin
        if (v1_r && adv2_s) begin
            gg2_r   <= lv[LEVELS].g_s;
            p2_r    <= p1_r;
            cin2_r  <= cin1_r;
            xmsb2_r <= xmsb1_r;
        end
    end

    assign carry_s = {gg2_r[N-2:0], cin2_r};
    assign sum_s   = p2_r ^ carry_s;

    // Stage 3: registered result and flags, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= {N{1'b0}};
            bout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv3_s) begin
            out_valid <= v2_r;
            if (v2_r) begin
                d    <= sum_s;
                bout <= ~gg2_r[N-1];
                zero <= (sum_s == {N{1'b0}});
                ovf  <= ~p2_r[N-1] & (sum_s[N-1] ^ xmsb2_r);
            end
        end
    end

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Directed and scoreboarded random checks of prefix_subtractor_pipe at N=8 and N=32.
module tb_prefix_subtractor_pipe;

    localparam int NB = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  x8, y8, d8;
    logic        bin8, bout8, zero8, ovf8;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] x32, y32, d32;
    logic        bin32, bout32, zero32, ovf32;

    logic [34:0] res8_w;
    logic [34:0] res32_w;

    int n_checks = 0;
    int n_fail   = 0;

    assign res8_w  = {ovf8, zero8, bout8, 24'd0, d8};
    assign res32_w = {ovf32, zero32, bout32, d32};

    always #5 clk = ~clk;

    prefix_subtractor_pipe #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x8), .y(y8), .bin(bin8), .out_valid(out_valid), .out_ready(out_ready),
        .d(d8), .bout(bout8), .zero(zero8), .ovf(ovf8)
    );

    prefix_subtractor_pipe #(.N(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .x(x32), .y(y32), .bin(bin32), .out_valid(out_valid32), .out_ready(out_ready32),
        .d(d32), .bout(bout32), .zero(zero32), .ovf(ovf32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {ovf, zero, bout, d[31:0]}.
    function automatic logic [34:0] ref_sub(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic c);
        logic [63:0] m;
        logic [63:0] dd;
        logic        bo, ov, z;
        m  = (64'd1 << w) - 64'd1;
        dd = ({32'd0, a} - {32'd0, b} - {63'd0, c}) & m;
        bo = ({32'd0, a} < ({32'd0, b} + {63'd0, c}));
        ov = (a[w-1] != b[w-1]) && (dd[w-1] != a[w-1]);
        z  = (dd == 64'd0);
        return {ov, z, bo, dd[31:0]};
    endfunction

    task automatic send_and_wait(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic [34:0] exp);
        int lat;
        in_valid = 1'b1;
        x8 = a;
        y8 = b;
        bin8 = c;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_result"}, 64'(res8_w), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  bx [5];
    logic [7:0]  by [5];
    logic        bb [5];
    logic [34:0] held;
    logic [34:0] e;
    logic        acc, acc32, fire, fire32;
    int          idx, ridx, first_c, last_c, stale;
    int          sent8, sent32, recv8, recv32, cycles;
    logic [34:0] q8 [$];
    logic [34:0] q32 [$];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; x8 = 8'd0; y8 = 8'd0; bin8 = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; x32 = 32'd0; y32 = 32'd0; bin32 = 1'b0; out_ready32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'(res8_w), 64'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Directed arithmetic vectors, expectations worked by hand.
        send_and_wait("v05m03", 8'h05, 8'h03, 1'b0, 35'h0_0000_0002);
        send_and_wait("v03m05", 8'h03, 8'h05, 1'b0, 35'h1_0000_00FE);
        send_and_wait("v00m00b", 8'h00, 8'h00, 1'b1, 35'h1_0000_00FF);
        send_and_wait("v80m01", 8'h80, 8'h01, 1'b0, 35'h4_0000_007F);
        send_and_wait("v7Fm7F", 8'h7F, 8'h7F, 1'b0, 35'h2_0000_0000);

        // Backpressure: five beats offered against a stalled consumer.
        for (int i = 0; i < 5; i++) begin
            bx[i] = 8'(i * 37 + 3);
            by[i] = 8'(i * 53 + 100);
            bb[i] = i[0];
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 5);
            x8 = bx[idx % 5]; y8 = by[idx % 5]; bin8 = bb[idx % 5];
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            #1;
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head", 64'(res8_w), 64'(ref_sub(8, {24'd0, bx[0]}, {24'd0, by[0]}, bb[0])));
        held = res8_w;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold", 64'(res8_w), 64'(held));
        out_ready = 1'b1;
        ridx = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx < 5);
            x8 = bx[idx % 5]; y8 = by[idx % 5]; bin8 = bb[idx % 5];
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready && ridx < 5) begin
                check("bp_order", 64'(res8_w),
                      64'(ref_sub(8, {24'd0, bx[ridx]}, {24'd0, by[ridx]}, bb[ridx])));
                if (ridx == 0) first_c = c;
                last_c = c;
                ridx++;
            end
            @(posedge clk);
            if (acc) idx++;
            #1;
        end
        in_valid = 1'b0;
        check("bp_drained", 64'(ridx), 64'd5);
        check("bp_no_gaps", 64'(last_c - first_c), 64'd4);

        // Reset with two beats in flight, one already presented at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x8 = 8'h40 + 8'(i); y8 = 8'h11; bin8 = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_outputs", 64'(res8_w), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("rst_no_stale", 64'(stale), 64'd0);

        // Random traffic on both widths, scoreboarded against the reference model.
        sent8 = 0; sent32 = 0; recv8 = 0; recv32 = 0; cycles = 0;
        while ((recv8 < NB || recv32 < NB) && cycles < 60000) begin
            in_valid    = (sent8 < NB) && ($urandom_range(0, 3) != 0);
            in_valid32  = (sent32 < NB) && ($urandom_range(0, 3) != 0);
            x8 = 8'($urandom); y8 = 8'($urandom); bin8 = 1'($urandom);
            x32 = $urandom; y32 = $urandom; bin32 = 1'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            out_ready32 = ($urandom_range(0, 3) != 0);
            #1;
            acc    = in_valid && in_ready;
            acc32  = in_valid32 && in_ready32;
            fire   = out_valid && out_ready;
            fire32 = out_valid32 && out_ready32;
            if (fire) begin
                if (q8.size() == 0) begin
                    check("rnd8_spurious", 64'd1, 64'd0);
                end else begin
                    e = q8.pop_front();
                    check("rnd8", 64'(res8_w), 64'(e));
                end
                recv8++;
            end
            if (fire32) begin
                if (q32.size() == 0) begin
                    check("rnd32_spurious", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    check("rnd32", 64'(res32_w), 64'(e));
                end
                recv32++;
            end
            if (acc) begin
                q8.push_back(ref_sub(8, {24'd0, x8}, {24'd0, y8}, bin8));
                sent8++;
            end
            if (acc32) begin
                q32.push_back(ref_sub(32, x32, y32, bin32));
                sent32++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        in_valid32 = 1'b0;
        check("rnd8_count", 64'(recv8), 64'(NB));
        check("rnd32_count", 64'(recv32), 64'(NB));
        check("rnd8_queue_empty", 64'(q8.size()), 64'd0);
        check("rnd32_queue_empty", 64'(q32.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
